// File: rtl/plaintext_writer_if.sv
`default_nettype none
// ============================================================================
// Module  : plaintext_writer_if
// Brief   : Draw request and character-memory write bus of plaintext_writer.
// Revision: 1.0
// ============================================================================
interface plaintext_writer_if;
    logic         draw_plaintext;
    logic [127:0] plaintext_to_draw;
    logic         char_ready;
    logic         char_we;
    logic [11:0]  char_addr;
    logic [7:0]   char_data;
    logic         done_drawing_plaintext;

    // master: the writer itself; slave: requester plus character memory
    modport master (
        input  draw_plaintext, plaintext_to_draw, char_ready,
        output char_we, char_addr, char_data, done_drawing_plaintext
    );
    modport slave (
        output draw_plaintext, plaintext_to_draw, char_ready,
        input  char_we, char_addr, char_data, done_drawing_plaintext
    );
endinterface
`default_nettype wire

// File: rtl/plaintext_writer.sv
`default_nettype none
// ============================================================================
// Module  : plaintext_writer
// Brief   : Writes a captured 16-character plaintext into one text-screen row.
// Revision: 1.0
// ============================================================================
module plaintext_writer #(
    parameter int ROW       = 10,
    parameter int COL_START = 32,
    parameter int COLS      = 80
) (
    input  wire logic              clk,
    input  wire logic              reset,
    plaintext_writer_if.master     bus
);

    localparam logic [1:0]  c_idle      = 2'd0;
    localparam logic [1:0]  c_write     = 2'd1;
    localparam logic [1:0]  c_done      = 2'd2;
    localparam logic [11:0] c_base_addr = 12'(ROW * COLS + COL_START);

    if (ROW * COLS + COL_START + 15 >= 4096) begin : g_cfg_error
        $error("plaintext_writer: ROW*COLS+COL_START+15 does not fit in 12 bits");
    end

    logic [1:0]   r_state;
    logic [4:0]   r_index;
    logic [127:0] r_text;
    logic         r_we;
    logic [11:0]  r_addr;
    logic [7:0]   r_data;
    logic         r_done;

    logic [4:0]   w_next_index;
    logic [127:0] w_shifted;
    logic         w_accept;

    function automatic logic [7:0] printable(input logic [7:0] b);
        return (b >= 8'h20 && b <= 8'h7E) ? b : 8'h3F;
    endfunction

    // Byte for the next index sits at the top after shifting out the consumed ones
    always_comb begin
        w_next_index = r_index + 5'd1;
        w_shifted    = r_text << {w_next_index, 3'b000};
        w_accept     = r_we && bus.char_ready;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state <= c_idle;
            r_index <= 5'd0;
            r_text  <= 128'd0;
            r_we    <= 1'b0;
            r_addr  <= 12'd0;
            r_data  <= 8'd0;
            r_done  <= 1'b0;
        end else begin
            case (r_state)
                c_idle: begin
                    if (bus.draw_plaintext) begin
                        r_text  <= bus.plaintext_to_draw;
                        r_index <= 5'd0;
                        r_state <= c_write;
                        r_we    <= 1'b1;
                        r_addr  <= c_base_addr;
                        r_data  <= printable(bus.plaintext_to_draw[127:120]);
                    end
                end
                c_write: begin
                    if (w_accept) begin
                        r_index <= w_next_index;
                        // A withdrawn request ends the draw silently, even on the last byte
                        if (!bus.draw_plaintext) begin
                            r_state <= c_idle;
                            r_we    <= 1'b0;
                        end else if (r_index == 5'd15) begin
                            r_state <= c_done;
                            r_we    <= 1'b0;
                            r_done  <= 1'b1;
                        end else begin
                            r_addr  <= c_base_addr + 12'(w_next_index);
                            r_data  <= printable(w_shifted[127:120]);
                        end
                    end
                end
                c_done: begin
                    if (!bus.draw_plaintext) begin
                        r_state <= c_idle;
                        r_done  <= 1'b0;
                    end
                end
                default: begin
                    r_state <= c_idle;
                    r_we    <= 1'b0;
                    r_done  <= 1'b0;
                end
            endcase
        end
    end

    assign bus.char_we                = r_we;
    assign bus.char_addr              = r_addr;
    assign bus.char_data              = r_data;
    assign bus.done_drawing_plaintext = r_done;

endmodule
`default_nettype wire

// File: tb/tb_plaintext_writer.sv
`default_nettype none
// ============================================================================
// Module  : tb_plaintext_writer
// Brief   : Scoreboard bench for plaintext_writer; monitor pops expected writes.
// Revision: 1.0
// ============================================================================
module tb_plaintext_writer;

    typedef struct packed {
        logic [11:0] addr;
        logic [7:0]  data;
    } wr_t;

    logic clk;
    logic reset;
    int   checks;
    int   errors;
    int   n_writes;
    int   n_we;
    wr_t  exp_q[$];

    logic        prev_stall;
    logic [11:0] prev_addr;
    logic [7:0]  prev_data;

    plaintext_writer_if bus_if ();

    plaintext_writer #(
        .ROW       (10),
        .COL_START (32),
        .COLS      (80)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus_if)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [7:0] exp_char(input logic [7:0] b);
        if (b < 8'h20 || b > 8'h7E) return 8'h3F;
        return b;
    endfunction

    task automatic push_text(input logic [127:0] txt, input int count);
        wr_t e;
        for (int i = 0; i < count; i++) begin
            e.addr = 12'(832 + i);
            e.data = exp_char(txt[127 - 8*i -: 8]);
            exp_q.push_back(e);
        end
    endtask

    // Monitor: pops one expected write per accepted cycle, checks stall stability
    always @(negedge clk) begin
        wr_t e;
        if (reset) begin
            prev_stall = 1'b0;
        end else begin
            if (bus_if.char_we) n_we++;
            if (prev_stall && bus_if.char_we) begin
                check("stall_addr_stable", 32'(bus_if.char_addr), 32'(prev_addr));
                check("stall_data_stable", 32'(bus_if.char_data), 32'(prev_data));
            end
            if (bus_if.char_we && bus_if.char_ready) begin
                if (exp_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_write: addr %0d data %0h with empty queue at %0t",
                             bus_if.char_addr, bus_if.char_data, $time);
                end else begin
                    e = exp_q.pop_front();
                    check("write_addr", 32'(bus_if.char_addr), 32'(e.addr));
                    check("write_data", 32'(bus_if.char_data), 32'(e.data));
                end
                n_writes++;
            end
            prev_stall = bus_if.char_we && !bus_if.char_ready;
            prev_addr  = bus_if.char_addr;
            prev_data  = bus_if.char_data;
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Full draw; returns number of posedges from raising draw to seeing done
    task automatic run_draw(input logic [127:0] txt, input bit toggle, output int latency);
        int w0;
        push_text(txt, 16);
        w0 = n_writes;
        n_we = 0;
        latency = 0;
        bus_if.plaintext_to_draw = txt;
        bus_if.draw_plaintext = 1'b1;
        for (int c = 0; c < 200; c++) begin
            tick();
            latency++;
            if (c == 0) bus_if.plaintext_to_draw = ~txt;
            if (toggle) bus_if.char_ready = ~bus_if.char_ready;
            if (bus_if.done_drawing_plaintext) break;
        end
        check("done_reached", 32'(bus_if.done_drawing_plaintext), 32'd1);
        check("writes_per_draw", 32'(n_writes - w0), 32'd16);
        check("queue_drained", 32'(exp_q.size()), 32'd0);
        check("done_no_we", 32'(bus_if.char_we), 32'd0);
        bus_if.char_ready = 1'b1;
    endtask

    task automatic release_draw();
        bus_if.draw_plaintext = 1'b0;
        tick();
        check("idle_done_low", 32'(bus_if.done_drawing_plaintext), 32'd0);
        check("idle_we_low", 32'(bus_if.char_we), 32'd0);
    endtask

    task automatic wait_writes(input int target);
        int c;
        for (c = 0; c < 100; c++) begin
            tick();
            if (n_writes == target) break;
        end
        check("wait_writes_bound", 32'(c < 100), 32'd1);
    endtask

    initial begin
        int lat;
        int base;
        bit done_seen;
        checks = 0;
        errors = 0;
        n_writes = 0;
        n_we = 0;
        prev_stall = 1'b0;
        bus_if.draw_plaintext = 1'b0;
        bus_if.plaintext_to_draw = '0;
        bus_if.char_ready = 1'b1;

        reset = 1'b1;
        #2;
        check("reset_we", 32'(bus_if.char_we), 32'd0);
        check("reset_done", 32'(bus_if.done_drawing_plaintext), 32'd0);
        check("reset_addr", 32'(bus_if.char_addr), 32'd0);
        check("reset_data", 32'(bus_if.char_data), 32'd0);
        tick();
        tick();
        reset = 1'b0;
        tick();
        check("idle_after_reset", 32'(bus_if.char_we), 32'd0);

        // Basic draw, ready held high
        run_draw("HELLO WORLD 2021", 1'b0, lat);
        check("done_latency", 32'(lat), 32'd17);
        check("we_cycles", 32'(n_we), 32'd16);
        release_draw();

        // Ready toggling each cycle
        bus_if.char_ready = 1'b1;
        run_draw("HELLO WORLD 2021", 1'b1, lat);
        release_draw();

        // Non-printable boundary bytes
        run_draw({8'h07, "ABCDEFGHIJKLMN", 8'h7F}, 1'b0, lat);
        release_draw();

        // Printable edges 0x20 / 0x7E, then hold draw after done
        run_draw("0123456789 ~{}|}", 1'b0, lat);
        for (int i = 0; i < 10; i++) begin
            tick();
            check("done_held", 32'(bus_if.done_drawing_plaintext), 32'd1);
            check("no_retrigger_we", 32'(bus_if.char_we), 32'd0);
        end
        release_draw();
        run_draw("SECOND DRAW TEXT", 1'b0, lat);
        check("second_draw_latency", 32'(lat), 32'd17);
        release_draw();

        // Asynchronous reset with index 7 presented
        push_text("RESETMIDWRITE!!!", 16);
        base = n_writes;
        bus_if.plaintext_to_draw = "RESETMIDWRITE!!!";
        bus_if.draw_plaintext = 1'b1;
        wait_writes(base + 7);
        check("idx7_addr", 32'(bus_if.char_addr), 32'd839);
        #2;
        reset = 1'b1;
        #1;
        check("async_reset_we", 32'(bus_if.char_we), 32'd0);
        check("async_reset_done", 32'(bus_if.done_drawing_plaintext), 32'd0);
        check("async_reset_addr", 32'(bus_if.char_addr), 32'd0);
        check("writes_before_reset", 32'(n_writes - base), 32'd7);
        exp_q.delete();
        bus_if.draw_plaintext = 1'b0;
        tick();
        tick();
        reset = 1'b0;
        for (int i = 0; i < 3; i++) begin
            tick();
            check("post_reset_quiet", 32'(bus_if.char_we), 32'd0);
        end
        run_draw("AFTER RESET 0001", 1'b0, lat);
        release_draw();

        // Draw withdrawn at index 4 while stalled
        push_text("DROPPED AT FOUR.", 5);
        base = n_writes;
        bus_if.plaintext_to_draw = "DROPPED AT FOUR.";
        bus_if.draw_plaintext = 1'b1;
        wait_writes(base + 4);
        bus_if.char_ready = 1'b0;
        bus_if.draw_plaintext = 1'b0;
        done_seen = 1'b0;
        for (int i = 0; i < 3; i++) begin
            tick();
            check("stall_we_held", 32'(bus_if.char_we), 32'd1);
        end
        check("stall_idx4_addr", 32'(bus_if.char_addr), 32'd836);
        bus_if.char_ready = 1'b1;
        for (int i = 0; i < 6; i++) begin
            tick();
            if (bus_if.done_drawing_plaintext) done_seen = 1'b1;
        end
        check("drop_no_done", 32'(done_seen), 32'd0);
        check("drop_writes", 32'(n_writes - base), 32'd5);
        check("drop_queue_drained", 32'(exp_q.size()), 32'd0);
        check("drop_idle_we", 32'(bus_if.char_we), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
